// File: rtl/pipe_pkg.sv
// Shared constants for the skid-buffered pipeline stage: state encoding and default widths.
package pipe_pkg;

    localparam int unsigned DATA_W_DEF = 96;
    localparam int unsigned CTRL_W_DEF = 24;
    localparam int unsigned PC_W_DEF   = 32;
    localparam int unsigned CNT_W_DEF  = 16;

    typedef logic [1:0] state_t;

    // Encoding equals the number of valid entries, so occupancy is a direct decode.
    localparam state_t StEmpty = 2'd0;
    localparam state_t StOne   = 2'd1;
    localparam state_t StTwo   = 2'd2;

    function automatic logic [1:0] occ_of(state_t s);
        unique case (s)
            StOne:   return 2'd1;
            StTwo:   return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// One payload slot (data, ctrl, pc) with load and clear; clear wins over load.
module pipe_entry #(
    parameter int unsigned DataW = 96,
    parameter int unsigned CtrlW = 24,
    parameter int unsigned PcW   = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [DataW-1:0] data_i,
    input  logic [CtrlW-1:0] ctrl_i,
    input  logic [PcW-1:0]   pc_i,
    output logic [DataW-1:0] data_o,
    output logic [CtrlW-1:0] ctrl_o,
    output logic [PcW-1:0]   pc_o
);

    logic [DataW-1:0] data_d, data_q;
    logic [CtrlW-1:0] ctrl_d, ctrl_q;
    logic [PcW-1:0]   pc_d, pc_q;

    always_comb begin
        data_d = data_q;
        ctrl_d = ctrl_q;
        pc_d   = pc_q;
        if (clear_i) begin
            data_d = '0;
            ctrl_d = '0;
            pc_d   = '0;
        end else if (load_i) begin
            data_d = data_i;
            ctrl_d = ctrl_i;
            pc_d   = pc_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
            ctrl_q <= '0;
            pc_q   <= '0;
        end else begin
            data_q <= data_d;
            ctrl_q <= ctrl_d;
            pc_q   <= pc_d;
        end
    end

    assign data_o = data_q;
    assign ctrl_o = ctrl_q;
    assign pc_o   = pc_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffered pipeline register; in_ready depends only on registered state.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CTRL_W = CTRL_W_DEF,
    parameter int unsigned PC_W   = PC_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [PC_W-1:0]   in_pc,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [PC_W-1:0]   out_pc,
    input  logic              out_ready,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_t state_d, state_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

    logic in_fire, out_fire;
    logic main_load, main_clr, main_from_skid;
    logic skid_load, skid_clr;

    logic [DATA_W-1:0] main_data, skid_data, main_data_in;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_in;
    logic [PC_W-1:0]   main_pc, skid_pc, main_pc_in;

    assign in_ready  = (state_q != StTwo);
    assign out_valid = (state_q != StEmpty);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            state_d  = StEmpty;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        main_load = 1'b1;
                        state_d   = StOne;
                    end
                end
                StOne: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        skid_load = 1'b1;
                        state_d   = StTwo;
                    end else if (out_fire) begin
                        // Drained slot is zeroed so bubbles carry no stale payload.
                        main_clr = 1'b1;
                        state_d  = StEmpty;
                    end
                end
                StTwo: begin
                    if (out_fire) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                        state_d        = StOne;
                    end
                end
                default: begin
                    state_d  = StEmpty;
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        main_data_in = main_from_skid ? skid_data : in_data;
        main_ctrl_in = main_from_skid ? skid_ctrl : in_ctrl;
        main_pc_in   = main_from_skid ? skid_pc   : in_pc;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, (in_valid & ~in_ready)};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StEmpty;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    pipe_entry #(
        .DataW (DATA_W),
        .CtrlW (CTRL_W),
        .PcW   (PC_W)
    ) u_main (
        .clk_i   (clk),
        .rst_ni  (reset),
        .load_i  (main_load),
        .clear_i (main_clr),
        .data_i  (main_data_in),
        .ctrl_i  (main_ctrl_in),
        .pc_i    (main_pc_in),
        .data_o  (main_data),
        .ctrl_o  (main_ctrl),
        .pc_o    (main_pc)
    );

    pipe_entry #(
        .DataW (DATA_W),
        .CtrlW (CTRL_W),
        .PcW   (PC_W)
    ) u_skid (
        .clk_i   (clk),
        .rst_ni  (reset),
        .load_i  (skid_load),
        .clear_i (skid_clr),
        .data_i  (in_data),
        .ctrl_i  (in_ctrl),
        .pc_i    (in_pc),
        .data_o  (skid_data),
        .ctrl_o  (skid_ctrl),
        .pc_o    (skid_pc)
    );

    assign out_data  = main_data;
    assign out_ctrl  = out_valid ? main_ctrl : '0;
    assign out_pc    = main_pc;
    assign occupancy = occ_of(state_q);
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: driver pushes accepted payloads, monitor pops on out_fire.
module tb_pipe_skid_reg;

    typedef struct packed {
        logic [95:0] d;
        logic [23:0] c;
        logic [31:0] p;
    } item_t;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [95:0] in_data;
    logic [23:0] in_ctrl;
    logic [31:0] in_pc;
    logic        in_ready;
    logic        out_valid;
    logic [95:0] out_data;
    logic [23:0] out_ctrl;
    logic [31:0] out_pc;
    logic        out_ready;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [95:0] s_out_data;
    logic [23:0] s_out_ctrl;
    logic [31:0] s_out_pc;
    logic [1:0]  s_occupancy;
    logic [3:0]  s_stall_cnt;

    item_t       sb[$];
    int          model_occ;
    int unsigned model_stall;
    bit          mon_en;
    int          n_tests;
    int          n_fail;

    pipe_skid_reg dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .in_pc     (in_pc),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .out_pc    (out_pc),
        .out_ready (out_ready),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    // Narrow-counter instance sharing stimulus, used for the wrap check.
    pipe_skid_reg #(.CNT_W(4)) dut_w4 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .in_pc     (in_pc),
        .in_ready  (s_in_ready),
        .out_valid (s_out_valid),
        .out_data  (s_out_data),
        .out_ctrl  (s_out_ctrl),
        .out_pc    (s_out_pc),
        .out_ready (out_ready),
        .occupancy (s_occupancy),
        .stall_cnt (s_stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [95:0] mk_data(input logic [31:0] pc);
        return {pc, ~pc, pc ^ 32'h5a5a_5a5a};
    endfunction

    function automatic logic [23:0] mk_ctrl(input logic [31:0] pc);
        return pc[23:0] | 24'h80_0001;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the bench model advances at the edge and returns 1 unit later.
    task automatic cycle(input bit iv, input logic [31:0] pc, input bit ordy, input bit fl);
        bit   in_f, out_f;
        item_t it;
        @(negedge clk);
        in_valid  = iv;
        in_pc     = pc;
        in_data   = mk_data(pc);
        in_ctrl   = mk_ctrl(pc);
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        in_f  = iv && (model_occ != 2);
        out_f = ordy && (model_occ != 0);
        if (iv && model_occ == 2) model_stall++;
        if (fl) begin
            model_occ = 0;
            sb.delete();
        end else begin
            model_occ = model_occ + int'(in_f) - int'(out_f);
            if (in_f) begin
                it.d = mk_data(pc);
                it.c = mk_ctrl(pc);
                it.p = pc;
                sb.push_back(it);
            end
        end
        #1;
    endtask

    task automatic model_reset();
        model_occ   = 0;
        model_stall = 0;
        sb.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 128'(out_valid), 128'(0));
        chk({tag, "_in_ready"},  128'(in_ready),  128'(1));
        chk({tag, "_occupancy"}, 128'(occupancy), 128'(0));
        chk({tag, "_out_pc"},    128'(out_pc),    128'(0));
        chk({tag, "_out_data"},  128'(out_data),  128'(0));
        chk({tag, "_out_ctrl"},  128'(out_ctrl),  128'(0));
        chk({tag, "_stall_cnt"}, 128'(stall_cnt), 128'(0));
    endtask

    // Monitor: samples 1 unit before each rising edge.
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            #4;
            if (mon_en) begin
                chk("mon_out_valid", 128'(out_valid), 128'(model_occ != 0));
                chk("mon_in_ready",  128'(in_ready),  128'(model_occ != 2));
                chk("mon_occupancy", 128'(occupancy), 128'(model_occ));
                chk("mon_stall_cnt", 128'(stall_cnt), 128'(model_stall[15:0]));
                chk("mon_stall_w4",  128'(s_stall_cnt), 128'(model_stall[3:0]));
                if (!out_valid) chk("mon_bubble_ctrl", 128'(out_ctrl), 128'(0));
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("mon_sb_underflow", 128'(1), 128'(0));
                    end else begin
                        it = sb.pop_front();
                        chk("mon_out_pc",   128'(out_pc),   128'(it.p));
                        chk("mon_out_data", 128'(out_data), 128'(it.d));
                        chk("mon_out_ctrl", 128'(out_ctrl), 128'(it.c));
                    end
                end
            end
        end
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        mon_en    = 1'b0;
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        #2;
        chk_reset_outputs("rst");
        @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;

        // Pass-through with out_ready held high
        cycle(1'b1, 32'h3000, 1'b1, 1'b0);
        chk("pt_occ0", 128'(occupancy), 128'(1));
        chk("pt_pc0",  128'(out_pc),    128'(32'h3000));
        cycle(1'b1, 32'h3004, 1'b1, 1'b0);
        chk("pt_occ1", 128'(occupancy), 128'(1));
        chk("pt_pc1",  128'(out_pc),    128'(32'h3004));
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("pt_drain", 128'(occupancy), 128'(0));

        // Skid fill then in-order drain
        cycle(1'b1, 32'h10, 1'b0, 1'b0);
        cycle(1'b1, 32'h14, 1'b0, 1'b0);
        chk("skid_occ",      128'(occupancy), 128'(2));
        chk("skid_in_ready", 128'(in_ready),  128'(0));
        chk("skid_head",     128'(out_pc),    128'(32'h10));
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("skid_next", 128'(out_pc), 128'(32'h14));
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("skid_empty", 128'(occupancy), 128'(0));

        // Stall counting in TWO
        cycle(1'b1, 32'h20, 1'b0, 1'b0);
        cycle(1'b1, 32'h24, 1'b0, 1'b0);
        repeat (5) cycle(1'b1, 32'h28, 1'b0, 1'b0);
        chk("stall_5", 128'(stall_cnt), 128'(5));

        // Flush from TWO with in_valid high
        cycle(1'b1, 32'h2c, 1'b0, 1'b1);
        chk("flush_occ",   128'(occupancy), 128'(0));
        chk("flush_valid", 128'(out_valid), 128'(0));
        chk("flush_ctrl",  128'(out_ctrl),  128'(0));
        chk("flush_stall", 128'(stall_cnt), 128'(6));
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("flush_nocap", 128'(occupancy), 128'(0));

        // Flush from ONE discards a same-cycle in_fire
        cycle(1'b1, 32'h30, 1'b0, 1'b0);
        cycle(1'b1, 32'h34, 1'b1, 1'b1);
        chk("flush1_occ", 128'(occupancy), 128'(0));
        cycle(1'b1, 32'h40, 1'b1, 1'b0);
        chk("post_flush_pc", 128'(out_pc), 128'(32'h40));
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle at occupancy 2
        cycle(1'b1, 32'h50, 1'b0, 1'b0);
        cycle(1'b1, 32'h54, 1'b0, 1'b0);
        chk("areset_pre", 128'(occupancy), 128'(2));
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk_reset_outputs("areset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cycle(1'b1, 32'h60, 1'b1, 1'b0);
        chk("post_reset_pc", 128'(out_pc), 128'(32'h60));
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Counter wrap on the 4-bit instance
        cycle(1'b1, 32'h70, 1'b0, 1'b0);
        cycle(1'b1, 32'h74, 1'b0, 1'b0);
        repeat (17) cycle(1'b1, 32'h78, 1'b0, 1'b0);
        chk("wrap_w16", 128'(stall_cnt),   128'(17));
        chk("wrap_w4",  128'(s_stall_cnt), 128'(1));
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("wrap_order", 128'(out_pc), 128'(32'h74));
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("sb_drained", 128'(sb.size()), 128'(0));

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
